// File: rtl/idct8_unified_cordic_inv.sv
`default_nettype none
// ============================================================================
// Module  : idct8_unified_cordic_inv
// Brief   : 8-point inverse unified-CORDIC final stage. Undoes the three Q14
//           pair rotations, bypasses indices 0/4 and streams 8 samples out.
// Revision: 1.0 - initial release
// ============================================================================
module idct8_unified_cordic_inv #(
  parameter int DATA_W = 16,
  parameter int FRAC   = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_sample,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_sample,
  output logic                     out_last,
  output logic                     out_sat
);

  localparam int PW = DATA_W + FRAC + 2;

  localparam logic [0:0] E_IDLE = 1'b0;
  localparam logic [0:0] E_EMIT = 1'b1;

  localparam logic signed [PW-1:0] c_c1 = PW'(16069);
  localparam logic signed [PW-1:0] c_s1 = PW'(-3196);
  localparam logic signed [PW-1:0] c_c2 = PW'(15137);
  localparam logic signed [PW-1:0] c_s2 = PW'(6270);
  localparam logic signed [PW-1:0] c_c3 = PW'(13623);
  localparam logic signed [PW-1:0] c_s3 = PW'(9102);

  localparam logic signed [PW-1:0] c_max = PW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] c_min = PW'(-(64'sd1 <<< (DATA_W - 1)));

  logic signed [DATA_W-1:0] r_x [8];
  logic signed [DATA_W-1:0] r_y [8];
  logic [7:0]               r_sat;
  logic [2:0]               r_cidx;
  logic [2:0]               r_eidx;
  logic                     r_x_full;
  logic [0:0]               r_state;
  logic [0:0]               w_state_nxt;

  logic                     w_accept;
  logic                     w_compute;
  logic                     w_issue;
  logic                     w_issue_last;
  logic signed [DATA_W-1:0] w_y [8];
  logic [7:0]               w_sat;

  function automatic logic signed [PW-1:0] sx(input logic signed [DATA_W-1:0] v);
    return {{(PW - DATA_W){v[DATA_W-1]}}, v};
  endfunction

  // Returns {sat_flag, value}: floor-shift back to sample scale, then clamp.
  function automatic logic [DATA_W:0] clip(input logic signed [PW-1:0] sum);
    logic signed [PW-1:0] sh;
    sh = sum >>> FRAC;
    if (sh > c_max)      return {1'b1, c_max[DATA_W-1:0]};
    else if (sh < c_min) return {1'b1, c_min[DATA_W-1:0]};
    else                 return {1'b0, sh[DATA_W-1:0]};
  endfunction

  assign in_ready = !r_x_full;
  assign w_accept = in_valid && in_ready;

  // Transposed rotation: pair p couples index p+1 (a) with index 7-p (b).
  for (genvar p = 0; p < 3; p++) begin : g_pair
    localparam logic signed [PW-1:0] c_c = (p == 0) ? c_c1 : (p == 1) ? c_c2 : c_c3;
    localparam logic signed [PW-1:0] c_s = (p == 0) ? c_s1 : (p == 1) ? c_s2 : c_s3;
    logic signed [PW-1:0] w_a_sum;
    logic signed [PW-1:0] w_b_sum;
    logic [DATA_W:0]      w_a_res;
    logic [DATA_W:0]      w_b_res;

    assign w_a_sum = sx(r_x[p+1]) * c_c + sx(r_x[7-p]) * c_s;
    assign w_b_sum = sx(r_x[7-p]) * c_c - sx(r_x[p+1]) * c_s;
    assign w_a_res = clip(w_a_sum);
    assign w_b_res = clip(w_b_sum);
    assign w_y[p+1]   = $signed(w_a_res[DATA_W-1:0]);
    assign w_y[7-p]   = $signed(w_b_res[DATA_W-1:0]);
    assign w_sat[p+1] = w_a_res[DATA_W];
    assign w_sat[7-p] = w_b_res[DATA_W];
  end

  assign w_y[0]   = r_x[0];
  assign w_y[4]   = r_x[4];
  assign w_sat[0] = 1'b0;
  assign w_sat[4] = 1'b0;

  // Emitter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= E_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Emitter next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      E_IDLE:  if (w_compute) w_state_nxt = E_EMIT;
      E_EMIT:  if ((r_eidx == 3'd7) && !w_compute) w_state_nxt = E_IDLE;
      default: w_state_nxt = E_IDLE;
    endcase
  end

  // Emitter decode
  always_comb begin
    w_issue      = (r_state == E_EMIT);
    w_issue_last = (r_state == E_EMIT) && (r_eidx == 3'd7);
  end

  // A new block may load while the previous one issues its final sample.
  assign w_compute = r_x_full && ((r_state == E_IDLE) || w_issue_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cidx     <= '0;
      r_eidx     <= '0;
      r_x_full   <= 1'b0;
      r_sat      <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      out_last   <= 1'b0;
      out_sat    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_x[r_cidx] <= in_sample;
        r_cidx      <= r_cidx + 3'd1;
        if (r_cidx == 3'd7) r_x_full <= 1'b1;
      end
      if (w_compute) begin
        r_x_full <= 1'b0;
        r_sat    <= w_sat;
        for (int i = 0; i < 8; i++) r_y[i] <= w_y[i];
      end
      out_valid <= w_issue;
      out_last  <= w_issue_last;
      if (w_issue) begin
        out_sample <= r_y[r_eidx];
        out_sat    <= r_sat[r_eidx];
        r_eidx     <= r_eidx + 3'd1;
      end else begin
        out_sample <= '0;
        out_sat    <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_idct8_unified_cordic_inv.sv
`default_nettype none
// ============================================================================
// Module  : tb_idct8_unified_cordic_inv
// Brief   : Directed plus randomized bench with an arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_idct8_unified_cordic_inv;
  localparam int DATA_W = 16;
  localparam int FRAC   = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic signed [DATA_W-1:0] in_sample = '0;
  logic in_ready, out_valid, out_last, out_sat;
  logic signed [DATA_W-1:0] out_sample;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int val;
    bit sat;
    bit last;
    int tol;
  } exp_t;

  exp_t exp_q[$];
  int   out_cyc[$];
  exp_t m_e;
  int   m_diff;

  idct8_unified_cordic_inv #(.DATA_W(DATA_W), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
    .out_valid(out_valid), .out_sample(out_sample),
    .out_last(out_last), .out_sat(out_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_out observed=%0d expected=no_output", out_sample);
      end
      if (exp_q.size() != 0) begin
        m_e = exp_q.pop_front();
        m_diff = int'(out_sample) - m_e.val;
        if (m_diff < 0) m_diff = -m_diff;
        checks++;
        assert (m_diff <= m_e.tol) else begin
          failures++;
          $error("FAIL out_sample observed=%0d expected=%0d tol=%0d", out_sample, m_e.val, m_e.tol);
        end
        checks++;
        assert ({out_sat, out_last} === {m_e.sat, m_e.last}) else begin
          failures++;
          $error("FAIL sat_last observed=%b%b expected=%b%b", out_sat, out_last, m_e.sat, m_e.last);
        end
      end
      out_cyc.push_back(cyc);
    end
  end

  function automatic longint cval(input int p);
    return (p == 0) ? 64'sd16069 : (p == 1) ? 64'sd15137 : 64'sd13623;
  endfunction

  function automatic longint sval(input int p);
    return (p == 0) ? -64'sd3196 : (p == 1) ? 64'sd6270 : 64'sd9102;
  endfunction

  // floor(n / 2^FRAC) using plain integer division
  function automatic longint fdiv(input longint n);
    longint d;
    d = 64'sd1 << FRAC;
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  task automatic push_one(input int v, input bit s, input bit last, input int tol);
    exp_t e;
    e.val = v; e.sat = s; e.last = last; e.tol = tol;
    exp_q.push_back(e);
  endtask

  task automatic push_list(input int y[8], input bit s[8]);
    for (int i = 0; i < 8; i++) push_one(y[i], s[i], i == 7, 0);
  endtask

  task automatic push_exact(input int x[8]);
    int y[8];
    bit s[8];
    longint a, b, v;
    int idx;
    for (int i = 0; i < 8; i++) begin y[i] = x[i]; s[i] = 1'b0; end
    for (int p = 0; p < 3; p++) begin
      a = x[p+1];
      b = x[7-p];
      for (int h = 0; h < 2; h++) begin
        v   = (h == 0) ? fdiv(a * cval(p) + b * sval(p)) : fdiv(b * cval(p) - a * sval(p));
        idx = (h == 0) ? p + 1 : 7 - p;
        if (v > 32767)       begin y[idx] = 32767;  s[idx] = 1'b1; end
        else if (v < -32768) begin y[idx] = -32768; s[idx] = 1'b1; end
        else                       y[idx] = int'(v);
      end
    end
    push_list(y, s);
  endtask

  // Forward final-stage rotation (the inverse of the DUT's transposed matrix)
  task automatic fwd(input int x[8], output int f[8]);
    longint a, b;
    for (int i = 0; i < 8; i++) f[i] = x[i];
    for (int p = 0; p < 3; p++) begin
      a = x[p+1];
      b = x[7-p];
      f[p+1] = int'(fdiv(a * cval(p) - b * sval(p)));
      f[7-p] = int'(fdiv(a * sval(p) + b * cval(p)));
    end
  endtask

  task automatic send(input int v);
    int guard;
    guard = 0;
    in_valid  = 1'b1;
    in_sample = DATA_W'(v);
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    checks++;
    assert (guard < 50) else begin
      failures++;
      $error("FAIL accept_timeout observed=in_ready_low expected=in_ready_high");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_block(input int x[8], input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        in_valid  = 1'b0;
        in_sample = DATA_W'($urandom);
        @(posedge clk); #1;
      end
      send(x[i]);
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 300) begin @(posedge clk); #1; guard++; end
    checks++;
    assert (guard < 300) else begin
      failures++;
      $error("FAIL drain_timeout observed=%0d expected=0 pending", exp_q.size());
    end
  endtask

  initial begin
    int x[8];
    int f[8];
    int y[8];
    bit s[8];
    int blk[16];
    int t_acc, n0, idx, low, guard;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert ({out_valid, out_last, out_sat, in_ready} === 4'b0001) else begin
      failures++;
      $error("FAIL reset_flags observed=%b expected=0001", {out_valid, out_last, out_sat, in_ready});
    end
    checks++;
    assert (out_sample === '0) else begin
      failures++;
      $error("FAIL reset_sample observed=%0d expected=0", out_sample);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Impulse
    x = '{0, 1000, 0, 0, 0, 0, 0, 0};
    y = '{0, 980, 0, 0, 0, 0, 0, 195};
    s = '{default: 1'b0};
    push_list(y, s);
    send_block(x, 1'b0);
    wait_drain();

    // Bypass, latency, and a sample offered while in_ready is low
    x = '{-123, 0, 0, 0, 456, 0, 0, 0};
    push_list(x, s);
    n0 = out_cyc.size();
    send_block(x, 1'b0);
    t_acc = cyc;
    checks++;
    assert (in_ready === 1'b0) else begin
      failures++;
      $error("FAIL ready_after_block observed=%b expected=0", in_ready);
    end
    in_valid  = 1'b1;
    in_sample = 16'sd12345;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();
    checks++;
    assert (out_cyc.size() > n0 && out_cyc[n0] == t_acc + 2) else begin
      failures++;
      $error("FAIL first_out_latency observed=%0d expected=%0d",
             (out_cyc.size() > n0) ? out_cyc[n0] - t_acc : -1, 2);
    end

    // Saturation
    x = '{0, 0, 0, 32767, 0, 32767, 0, 0};
    y = '{0, 0, 0, 32767, 0, 9041, 0, 0};
    s = '{0, 0, 0, 1, 0, 0, 0, 0};
    push_list(y, s);
    send_block(x, 1'b0);
    wait_drain();

    // Back-to-back with in_valid held high, full-range random data
    for (int i = 0; i < 16; i++) blk[i] = int'($urandom_range(65535)) - 32768;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) x[i] = blk[b*8 + i];
      push_exact(x);
    end
    n0 = out_cyc.size();
    idx = 0; low = 0; guard = 0;
    in_valid = 1'b1;
    while (idx < 16 && guard < 100) begin
      in_sample = DATA_W'(blk[idx]);
      if (in_ready) idx++;
      else low++;
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    assert (in_ready === 1'b0) else begin
      failures++;
      $error("FAIL b2b_ready_after_16 observed=%b expected=0", in_ready);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    assert (in_ready === 1'b1) else begin
      failures++;
      $error("FAIL b2b_ready_recover observed=%b expected=1", in_ready);
    end
    checks++;
    assert (idx == 16 && low == 1) else begin
      failures++;
      $error("FAIL b2b_ready_low observed=%0d expected=1 (accepted %0d)", low, idx);
    end
    wait_drain();
    checks++;
    assert (out_cyc.size() - n0 == 16 && out_cyc[n0 + 8] - out_cyc[n0 + 7] <= 2) else begin
      failures++;
      $error("FAIL b2b_outputs observed=%0d outputs expected=16 with gap<=1",
             out_cyc.size() - n0);
    end

    // Round trip through the forward stage, random idle gaps
    for (int b = 0; b < 100; b++) begin
      for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(15998)) - 7999;
      fwd(x, f);
      for (int i = 0; i < 8; i++) push_one(x[i], 1'b0, i == 7, 2);
      send_block(f, 1'b1);
    end
    wait_drain();

    // Full-range random blocks against the exact model
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(65535)) - 32768;
      push_exact(x);
      send_block(x, 1'b1);
    end
    wait_drain();

    // Reset during the index-3 output
    x = '{11, 22, 33, 44, 55, 66, 77, 88};
    push_exact(x);
    send_block(x, 1'b0);
    t_acc = cyc;
    guard = 0;
    while (cyc < t_acc + 5 && guard < 20) begin @(posedge clk); #1; guard++; end
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    assert ({out_valid, out_last, out_sat, in_ready} === 4'b0001 && out_sample === '0) else begin
      failures++;
      $error("FAIL reset_mid_emit observed=%b/%0d expected=0001/0",
             {out_valid, out_last, out_sat, in_ready}, out_sample);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n0 = out_cyc.size();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert (out_cyc.size() == n0) else begin
      failures++;
      $error("FAIL no_partial_output observed=%0d expected=0", out_cyc.size() - n0);
    end
    x = '{0, 1000, 0, 0, 0, 0, 0, 0};
    y = '{0, 980, 0, 0, 0, 0, 0, 195};
    s = '{default: 1'b0};
    push_list(y, s);
    send_block(x, 1'b0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
